// File: rtl/morse_display_sequencer.sv
// Character buffer, scroll sequencer and display clock divider for the Morse 7-segment path.
// Characters are packed slot 0 at the MSB end of both buses; char_pos scrolls through filled slots.
module morse_display_sequencer #(
    parameter int DIV_LOG2    = 2,
    parameter int STEP_CYCLES = 25000000,
    parameter int STEP_W      = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [4:0]  char_code,
    input  logic [2:0]  char_len,
    output logic        char_ready,
    input  logic        start,
    input  logic        clear,
    output logic        clk_divider,
    output logic [2:0]  char_pos,
    output logic [39:0] final_seq_of_in,
    output logic [23:0] final_num_of_in,
    output logic [3:0]  char_count,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, SCROLL, HOLD} state_t;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    state_t              state, state_nxt;
    logic [DIV_LOG2-1:0] div_cnt;
    logic [STEP_W-1:0]   step_cnt, step_nxt;
    logic [2:0]          pos_nxt;
    logic                done_nxt;
    logic [4:0]          slot_code [8];
    logic [2:0]          slot_len  [8];
    logic                wr, start_ok, last_step, final_pos;

    assign char_ready  = (char_count < 4'd8) && !clear && !reset;
    assign wr          = char_valid && char_ready;
    // A start against an empty buffer has nothing to show, so it is dropped.
    assign start_ok    = start && (char_count != 4'd0);
    assign last_step   = (step_cnt == STEP_LAST);
    assign final_pos   = (char_pos == 3'd7) || (({1'b0, char_pos} + 4'd1) >= char_count);
    assign busy        = (state == SCROLL);
    assign clk_divider = div_cnt[DIV_LOG2-1];

    always_ff @(posedge clk) begin
        if (reset) div_cnt <= '0;
        else       div_cnt <= div_cnt + DIV_LOG2'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            char_count <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                slot_code[i] <= 5'd0;
                slot_len[i]  <= 3'd0;
            end
        end else if (wr) begin
            char_count <= char_count + 4'd1;
            for (int i = 0; i < 8; i++) begin
                if (char_count[2:0] == 3'(i)) begin
                    slot_code[i] <= char_code;
                    slot_len[i]  <= char_len;
                end
            end
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_pack
        assign final_seq_of_in[39-5*i -: 5] = slot_code[i];
        assign final_num_of_in[23-3*i -: 3] = slot_len[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            char_pos <= 3'd0;
            step_cnt <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            char_pos <= pos_nxt;
            step_cnt <= step_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pos_nxt   = char_pos;
        step_nxt  = step_cnt;
        done_nxt  = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            pos_nxt   = 3'd0;
            step_nxt  = '0;
        end else if (start_ok) begin
            state_nxt = SCROLL;
            pos_nxt   = 3'd0;
            step_nxt  = '0;
        end else begin
            case (state)
                IDLE: pos_nxt = 3'd0;
                SCROLL: begin
                    if (last_step) begin
                        step_nxt = '0;
                        // Last filled slot already shown: park on it rather than wrap.
                        if (final_pos) begin
                            state_nxt = HOLD;
                            done_nxt  = 1'b1;
                        end else begin
                            pos_nxt = char_pos + 3'd1;
                        end
                    end else begin
                        step_nxt = step_cnt + STEP_W'(1);
                    end
                end
                HOLD:    ;
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_display_sequencer.sv
// Directed table-driven bench for morse_display_sequencer with a small buffer/divider model.
module tb_morse_display_sequencer;
    logic        clk = 1'b0;
    logic        reset, char_valid, start, clear;
    logic [4:0]  char_code;
    logic [2:0]  char_len;
    logic        char_ready, clk_divider, busy, done;
    logic [2:0]  char_pos;
    logic [39:0] final_seq_of_in;
    logic [23:0] final_num_of_in;
    logic [3:0]  char_count;

    int nchecks = 0;
    int nerr    = 0;

    morse_display_sequencer #(.DIV_LOG2(2), .STEP_CYCLES(3), .STEP_W(4)) dut (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char_code(char_code),
        .char_len(char_len), .char_ready(char_ready), .start(start), .clear(clear),
        .clk_divider(clk_divider), .char_pos(char_pos), .final_seq_of_in(final_seq_of_in),
        .final_num_of_in(final_num_of_in), .char_count(char_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] code;
        logic [2:0] len;
        logic       start;
        logic       clear;
        logic       rdy;
        logic [3:0] cnt;
        logic       busy;
        logic [2:0] pos;
        logic       done;
    } vec_t;

    vec_t       tbl[$];
    logic [4:0] m_code [8];
    logic [2:0] m_len  [8];
    int         m_cnt;
    logic [1:0] ref_div;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void v(logic valid, logic [4:0] code, logic [2:0] len, logic st,
                               logic clr, logic rdy, logic [3:0] cnt, logic bsy,
                               logic [2:0] pos, logic dn);
        vec_t t;
        t.valid = valid; t.code = code; t.len = len; t.start = st; t.clear = clr;
        t.rdy = rdy; t.cnt = cnt; t.busy = bsy; t.pos = pos; t.done = dn;
        tbl.push_back(t);
    endfunction

    task automatic model_clear();
        m_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            m_code[i] = 5'd0;
            m_len[i]  = 3'd0;
        end
    endtask

    function automatic logic [39:0] exp_seq();
        logic [39:0] s = '0;
        for (int i = 0; i < 8; i++) s[39-5*i -: 5] = m_code[i];
        return s;
    endfunction

    function automatic logic [23:0] exp_num();
        logic [23:0] s = '0;
        for (int i = 0; i < 8; i++) s[23-3*i -: 3] = m_len[i];
        return s;
    endfunction

    task automatic apply(input vec_t t);
        char_valid = t.valid; char_code = t.code; char_len = t.len;
        start = t.start; clear = t.clear;
        #1;
        chk("char_ready", char_ready, t.rdy);
        @(posedge clk);
        if (t.clear) model_clear();
        else if (t.valid && t.rdy && m_cnt < 8) begin
            m_code[m_cnt] = t.code;
            m_len[m_cnt]  = t.len;
            m_cnt++;
        end
        ref_div = ref_div + 2'd1;
        #1;
        chk("char_count", char_count, t.cnt);
        chk("busy", busy, t.busy);
        chk("char_pos", char_pos, t.pos);
        chk("done", done, t.done);
        chk("seq_bus", final_seq_of_in, exp_seq());
        chk("num_bus", final_num_of_in, exp_num());
        chk("clk_divider", clk_divider, ref_div[1]);
    endtask

    task automatic run_table();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
        char_valid = 0; start = 0; clear = 0;
    endtask

    task automatic idle(input int n, input logic [3:0] cnt, input logic bsy,
                        input logic [2:0] pos, input logic dn);
        for (int i = 0; i < n; i++) v(0, 0, 0, 0, 0, cnt != 4'd8, cnt, bsy, pos, dn);
    endtask

    initial begin
        reset = 1; char_valid = 0; char_code = 0; char_len = 0; start = 0; clear = 0;
        model_clear();
        ref_div = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", char_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pos", char_pos, 0);
        chk("rst_done", done, 0);
        chk("rst_seq", final_seq_of_in, 0);
        chk("rst_num", final_num_of_in, 0);
        chk("rst_div", clk_divider, 0);
        reset = 0;
        #1;
        chk("rst_ready", char_ready, 1);

        // Single write of 'A'
        v(1, 5'b00010, 3'd2, 0, 0, 1, 1, 0, 0, 0);
        run_table();
        chk("A_code", final_seq_of_in[39:35], 5'b00010);
        chk("A_len", final_num_of_in[23:21], 3'b010);
        #1;
        chk("A_ready", char_ready, 1);

        // Nine back-to-back writes; ninth must be refused
        v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            v(1, 5'(i + 1), 3'(i % 8), 0, 0, i < 8, (i < 8) ? 4'(i + 1) : 4'd8, 0, 0, 0);
        idle(2, 8, 0, 0, 0);
        run_table();
        chk("slot7_code", final_seq_of_in[4:0], 5'd8);
        chk("slot7_len", final_num_of_in[2:0], 3'd7);
        chk("slot0_len0", final_num_of_in[23:21], 3'd0);

        // Three characters, full scroll pass
        v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        v(1, 5'h15, 3'd3, 0, 0, 1, 1, 0, 0, 0);
        v(1, 5'h0a, 3'd4, 0, 0, 1, 2, 0, 0, 0);
        v(1, 5'h1f, 3'd5, 0, 0, 1, 3, 0, 0, 0);
        v(0, 0, 0, 1, 0, 1, 3, 1, 0, 0);
        idle(2, 3, 1, 0, 0);
        idle(3, 3, 1, 1, 0);
        idle(3, 3, 1, 2, 0);
        idle(1, 3, 0, 2, 1);
        idle(2, 3, 0, 2, 0);
        // Restart from HOLD, then restart mid-pass at pos 2
        v(0, 0, 0, 1, 0, 1, 3, 1, 0, 0);
        idle(2, 3, 1, 0, 0);
        idle(3, 3, 1, 1, 0);
        idle(1, 3, 1, 2, 0);
        v(0, 0, 0, 1, 0, 1, 3, 1, 0, 0);
        idle(1, 3, 1, 0, 0);
        // Clear with a simultaneous write during SCROLL
        v(1, 5'h07, 3'd2, 0, 1, 0, 0, 0, 0, 0);
        idle(3, 0, 0, 0, 0);
        // Start on empty buffer; write+start with count 0
        v(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        idle(1, 0, 0, 0, 0);
        v(1, 5'h03, 3'd2, 1, 0, 1, 1, 0, 0, 0);
        idle(1, 1, 0, 0, 0);
        // Start coinciding with the final step suppresses done
        v(0, 0, 0, 1, 0, 1, 1, 1, 0, 0);
        idle(2, 1, 1, 0, 0);
        v(0, 0, 0, 1, 0, 1, 1, 1, 0, 0);
        idle(2, 1, 1, 0, 0);
        idle(1, 1, 0, 0, 1);
        idle(1, 1, 0, 0, 0);
        // Write during SCROLL extends the pass
        v(0, 0, 0, 1, 0, 1, 1, 1, 0, 0);
        v(1, 5'h01, 3'd1, 0, 0, 1, 2, 1, 0, 0);
        idle(1, 2, 1, 0, 0);
        idle(3, 2, 1, 1, 0);
        idle(1, 2, 0, 1, 1);
        v(0, 0, 0, 1, 0, 1, 2, 1, 0, 0);
        idle(1, 2, 1, 0, 0);
        run_table();

        // Reset in the middle of a pass
        reset = 1;
        @(posedge clk);
        model_clear();
        ref_div = 2'd0;
        #1;
        chk("mid_rst_count", char_count, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pos", char_pos, 0);
        chk("mid_rst_seq", final_seq_of_in, 0);
        chk("mid_rst_div", clk_divider, 0);
        reset = 0;
        #1;
        chk("mid_rst_ready", char_ready, 1);
        idle(6, 0, 0, 0, 0);
        run_table();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/morse_display_sequencer.md
Name: morse_display_sequencer

Overview:
- Controller that owns the 8-slot character buffer and the scroll position for the 7-segment display path.
- Accepts decoded Morse characters (5-bit code plus 3-bit input count) through a valid/ready handshake and packs them into the 40-bit sequence and 24-bit count buses.
- Steps char_pos through the 8 display positions at a programmable rate, and generates the divided display clock the last-letter display stage samples on.

Parameters:
- DIV_LOG2, 2, clk_divider period is 2^DIV_LOG2 clk cycles (default: 4x slower); 50% duty.
- STEP_CYCLES, 25000000, clk cycles per scroll step; must be >= 1.
- STEP_W, 25, width of the step counter; 2^STEP_W must exceed STEP_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- char_valid  input  1  character offered this cycle.
- char_code  input  5  dot/dash pattern of the offered character.
- char_len  input  3  number of Morse inputs in the character, 1..5.
- char_ready  output  1  buffer can accept a character.
- start  input  1  one-cycle pulse that begins a scroll pass.
- clear  input  1  one-cycle pulse that empties the buffer and stops the scroll.
- clk_divider  output  1  divided display clock.
- char_pos  output  3  current display position.
- final_seq_of_in  output  40  packed codes; slot i occupies bits [39-5i : 35-5i].
- final_num_of_in  output  24  packed lengths; slot i occupies bits [23-3i : 21-3i].
- char_count  output  4  number of filled slots, 0..8.
- busy  output  1  high while in SCROLL.
- done  output  1  one-cycle pulse at the end of a pass.

Behaviour:
- Everything updates on the posedge of clk.
- Reset values: all outputs 0; state IDLE; step counter 0; divider counter 0; every buffer slot 0. char_ready therefore reads 1 on the first cycle after reset (count 0, not in reset).
- Divider:
  - A free-running DIV_LOG2-bit counter runs continuously; clk_divider is its MSB.
  - Only reset affects it; clear and start do not.
- Write handshake:
  - char_ready = (char_count < 8) && !clear.
  - A write occurs when char_valid && char_ready. Slot[char_count] is loaded with char_code/char_len and char_count increments on the same edge; the new data is visible on the buses the next cycle.
  - A write with char_count == 8 is ignored: no slot changes, count stays 8.
  - char_len values 0, 6 and 7 are stored unmodified; the display decoder blanks them.
- State machine:
  - IDLE:
    - char_pos = 0.
    - start && char_count != 0 -> SCROLL; char_pos = 0, step counter = 0.
    - start with char_count == 0 is ignored.
  - SCROLL:
    - The step counter increments every cycle. When it reaches STEP_CYCLES-1 it wraps to 0 and char_pos increments.
    - The step in which char_pos would advance past char_count-1 (or past 7) instead goes to HOLD and pulses done for 1 cycle; char_pos is left unchanged.
    - Writes remain allowed during SCROLL and extend the pass if they land before the final step.
  - HOLD:
    - char_pos is frozen; busy = 0.
    - start -> SCROLL from position 0.
- Simultaneous events:
  - clear in any state: buffer slots, char_count, char_pos and the step counter all go to 0, state goes to IDLE, done = 0.
  - clear overrides a same-cycle write and a same-cycle start.
  - start during SCROLL restarts the pass at char_pos 0 with the step counter at 0.
  - start on the same cycle as a final step: start wins; no done pulse.
  - A write and a start on the same cycle with count 0: the write is taken, the start is ignored (the count was 0 when start was evaluated).
- Reset mid-operation: identical to the reset values above, regardless of state.

Test Plan:
- Reset, then write 'A' (code 5'b00010, len 2) -> final_seq_of_in[39:35] = 00010, final_num_of_in[23:21] = 010, char_count = 1, char_ready = 1.
- Write 9 characters back to back with char_valid held high -> char_ready drops after the 8th write, char_count = 8, the 9th character is absent from both buses, slot 7 sits in [4:0] and [2:0].
- STEP_CYCLES = 3, fill 3 characters, pulse start -> busy = 1, char_pos 0, 1, 2 each held 3 cycles, done pulses once on the next step boundary, char_pos stays at 2, busy = 0.
- Pulse clear on the same cycle as a valid write during SCROLL -> next cycle both buses are 0, char_count = 0, char_pos = 0, busy = 0, done never asserts.
- Pulse start with an empty buffer -> state stays IDLE, busy = 0. Pulse start during SCROLL at char_pos = 2 -> char_pos = 0 on the next cycle.
- DIV_LOG2 = 2, sampled over 16 clk cycles after reset -> clk_divider sequence 0,0,1,1 repeating, unaffected by a clear pulse partway through.
